// File: rtl/arithmetic_left_shift_saturating_serial_pkg.sv
// Shared types and saturation constants for the serial saturating left shifter.
//   shl_state_t : FSM encoding (IDLE, SHIFT, DONE)
//   sat_max(n)  : largest positive n-bit two's complement value, zero-extended
//   sat_min(n)  : most negative n-bit two's complement value, as an n-bit pattern
package arith_shift_pkg;

  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shl_state_t;

  // {0, {n-1{1}}}
  function automatic logic [SAT_W-1:0] sat_max(input int unsigned n);
    return (SAT_W'(1) << (n - 1)) - SAT_W'(1);
  endfunction

  // {1, {n-1{0}}}
  function automatic logic [SAT_W-1:0] sat_min(input int unsigned n);
    return SAT_W'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/arithmetic_left_shift_saturating_serial_if.sv
// Operand/result handshake bundle for the serial saturating left shifter.
//   in_valid/in_ready/in_data/in_shift     : operand channel (master -> slave)
//   out_valid/out_ready/out_data/out_overflow : result channel (slave -> master)
interface arithmetic_left_shift_saturating_serial_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_overflow;

  modport master (
    output in_valid, in_data, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/arithmetic_left_shift_saturating_serial_one_step.sv
// One combinational step of a signed left shift.
//   d        : current value
//   shl      : d shifted left by one, zero filled
//   ovf_step : set when this step changes the sign (top two bits differ)
module arithmetic_left_shift_one_step #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] d,
  output logic [N-1:0] shl,
  output logic         ovf_step
);
  assign shl      = {d[N-2:0], 1'b0};
  assign ovf_step = d[N-1] ^ d[N-2];
endmodule

// File: rtl/arithmetic_left_shift_saturating_serial.sv
// Serial signed multiply-by-2^k with saturation, one bit per clock.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : slave side of the operand/result handshake
//                (in_valid/in_ready/in_data/in_shift, out_valid/out_ready/out_data/out_overflow)
module arithmetic_left_shift_saturating_serial
  import arith_shift_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 4
) (
  input  logic clk,
  input  logic rst_n,
  arithmetic_left_shift_saturating_serial_if.slave bus
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [N-1:0] MAX_V = N'(sat_max(N));
  localparam logic [N-1:0] MIN_V = N'(sat_min(N));

  shl_state_t    state_q, state_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          sign_q, sign_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_overflow_q, out_overflow_d;

  logic [CW-1:0] cnt_load;
  logic [N-1:0]  shl;
  logic          ovf_step;

  arithmetic_left_shift_one_step #(.N(N)) u_step (
    .d        (d_q),
    .shl      (shl),
    .ovf_step (ovf_step)
  );

  // Shift counts beyond N all saturate identically, so clamp to N.
  always_comb begin
    cnt_load = '0;
    if (32'(bus.in_shift) >= N) cnt_load = CW'(N);
    else                        cnt_load = CW'(bus.in_shift);
  end

  // Next-state and registered-output logic; results are formed on entry to DONE.
  always_comb begin
    state_d        = state_q;
    d_d            = d_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    sign_d         = sign_q;
    out_data_d     = out_data_q;
    out_overflow_d = out_overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          d_d    = bus.in_data;
          sign_d = bus.in_data[N-1];
          ovf_d  = 1'b0;
          cnt_d  = cnt_load;
          if (cnt_load == '0) begin
            state_d        = DONE;
            out_data_d     = bus.in_data;
            out_overflow_d = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        d_d   = shl;
        ovf_d = ovf_q | ovf_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d        = DONE;
          out_overflow_d = ovf_d;
          if (ovf_d) out_data_d = sign_q ? MIN_V : MAX_V;
          else       out_data_d = shl;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      d_q            <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      sign_q         <= 1'b0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      d_q            <= d_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      sign_q         <= sign_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_overflow_q <= out_overflow_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_overflow_q;

endmodule

// File: tb/tb_arithmetic_left_shift_saturating_serial.sv
// Self-checking bench for arithmetic_left_shift_saturating_serial (N=8, SW=4).
module tb_arithmetic_left_shift_saturating_serial;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_mode = 1'b0;

  // Reference-side bookkeeping of the one operand that may be in flight.
  logic [8:0] exp_q[$];
  bit         pending = 1'b0;
  int         ready_cyc = 0;

  arithmetic_left_shift_saturating_serial_if #(.N(8), .SW(4)) bus ();

  arithmetic_left_shift_saturating_serial #(.N(8), .SW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc = cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // {ovf, result} = saturate(a * 2^min(k,8)) in plain integer arithmetic.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [3:0] k);
    int m;
    int p;
    m = (int'(k) > 8) ? 8 : int'(k);
    p = int'($signed(a)) * (1 << m);
    if (p > 127)  return {1'b1, 8'h7F};
    if (p < -128) return {1'b1, 8'h80};
    return {1'b0, 8'(p)};
  endfunction

  function automatic int min_k(input logic [3:0] k);
    return (int'(k) > 8) ? 8 : int'(k);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // Per-cycle compare of the DUT against the model.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pending = 1'b0;
      exp_q.delete();
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(!pending));
      chk("out_valid", 32'(bus.out_valid), 32'(pending && (cyc >= ready_cyc)));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(1), 32'(0));
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q[0][7:0]));
          chk("out_overflow", 32'(bus.out_overflow), 32'(exp_q[0][8]));
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          pending = 1'b0;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_data, bus.in_shift));
        pending   = 1'b1;
        ready_cyc = cyc + 1 + min_k(bus.in_shift);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Present an operand and hold it until accepted; returns the accept cycle.
  task automatic send(input logic [7:0] a, input logic [3:0] k, output int t_acc, output bit ok);
    ok = 1'b0;
    t_acc = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    bus.in_shift = k;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        t_acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_valid(output int t_val, output bit ok);
    ok = 1'b0;
    t_val = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        t_val = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("out_valid_timeout", 32'(0), 32'(1));
  endtask

  // Directed operation with hand-computed result and latency.
  task automatic do_op(input string nm, input logic [7:0] a, input logic [3:0] k,
                       input logic [7:0] ed, input logic eo, input int elat);
    int t0, t1;
    bit ok0, ok1;
    send(a, k, t0, ok0);
    @(negedge clk);
    wait_valid(t1, ok1);
    if (ok0 && ok1) begin
      chk({nm, "_latency"}, 32'(t1 - t0), 32'(elat));
      chk({nm, "_data"}, 32'(bus.out_data), 32'(ed));
      chk({nm, "_ovf"}, 32'(bus.out_overflow), 32'(eo));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1;
    bit ok0, ok1;
    logic [7:0] held_d;
    logic       held_o;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shift  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_out_overflow", 32'(bus.out_overflow), 32'(0));

    chk("model_05_3", 32'(model(8'h05, 4'd3)), 32'(9'h028));
    chk("model_30_2", 32'(model(8'h30, 4'd2)), 32'(9'h17F));
    chk("model_c0_1", 32'(model(8'hC0, 4'd1)), 32'(9'h080));
    chk("model_c0_2", 32'(model(8'hC0, 4'd2)), 32'(9'h180));
    chk("model_01_15", 32'(model(8'h01, 4'd15)), 32'(9'h17F));

    do_op("pos_k3",   8'h05, 4'd3,  8'h28, 1'b0, 4);
    do_op("neg_k2",   8'hF6, 4'd2,  8'hD8, 1'b0, 3);
    do_op("sat_pos",  8'h30, 4'd2,  8'h7F, 1'b1, 3);
    do_op("min_exact",8'hC0, 4'd1,  8'h80, 1'b0, 2);
    do_op("sat_neg",  8'hC0, 4'd2,  8'h80, 1'b1, 3);
    do_op("k0",       8'h81, 4'd0,  8'h81, 1'b0, 1);
    do_op("zero_k15", 8'h00, 4'd15, 8'h00, 1'b0, 9);
    do_op("one_k15",  8'h01, 4'd15, 8'h7F, 1'b1, 9);
    do_op("neg_k8",   8'hFF, 4'd8,  8'h80, 1'b1, 9);

    // Back-pressure: result held, new operands refused.
    bus.out_ready = 1'b0;
    send(8'h30, 4'd2, t0, ok0);
    @(negedge clk);
    wait_valid(t1, ok1);
    held_d = bus.out_data;
    held_o = bus.out_overflow;
    chk("bp_data", 32'(held_d), 32'(8'h7F));
    chk("bp_ovf", 32'(held_o), 32'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i % 2 == 0);
      bus.in_data  = 8'h11;
      bus.in_shift = 4'd1;
      @(negedge clk);
      chk("bp_hold_data", 32'(bus.out_data), 32'(8'h7F));
      chk("bp_hold_ovf", 32'(bus.out_overflow), 32'(1));
      chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ready_after", 32'(bus.in_ready), 32'(1));
    chk("bp_valid_after", 32'(bus.out_valid), 32'(0));

    // Reset during SHIFT drops the operand.
    send(8'h05, 4'd7, t0, ok0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_mid_ready", 32'(bus.in_ready), 32'(1));
    do_op("after_rst", 8'h03, 4'd1, 8'h06, 1'b0, 2);

    // Random operands with random gaps and output stalls.
    rnd_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] a;
      logic [3:0] k;
      a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = 8'($signed(3'($urandom)));
      k = 4'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(a, k, t0, ok0);
    end
    for (int i = 0; i < 200 && pending; i++) @(negedge clk);
    chk("drain", 32'(pending), 32'(0));
    rnd_mode = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
